// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the RV32I core: register index width,
// load/store unit states and funct3 width encodings.
package singlecycle_pkg;
  localparam int REGIDX_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WB,
    DONE,
    FAULT
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the LSU: store lane steering, byte strobes,
// load extraction/extension and operation legality (LSU_MISALIGN_CHECK_EN adds alignment faults).
module lsu_align
  import singlecycle_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        bad
);
  logic [1:0]  sh;
  logic [31:0] shifted;
  logic        misalign;

  // Low address bits below the access size are dropped, so a halfword at
  // offset 3 reads lanes 3:2 and a word ignores addr_lo entirely.
  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    sh    = 2'b00;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
        sh    = addr_lo;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        sh    = {addr_lo[1], 1'b0};
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b1111;
        sh    = 2'b00;
      end
    endcase
    if (!is_store) wstrb = 4'b0000;
  end

  assign shifted = rdata >> {sh, 3'b000};

  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad = !f3_legal(is_store, funct3) || misalign;
endmodule

// File: rtl/lsu_wb.sv
// RV32I load/store + writeback unit: one operation in flight, valid/ready memory
// request, separate read strobe, one-cycle register write. Option: LSU_MISALIGN_CHECK_EN.
module lsu_wb
  import singlecycle_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_is_store,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_addr,
  input  logic [31:0]             i_store_data,
  input  logic [REGIDX_WIDTH-1:0] i_rd_addr,
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic [31:0]             o_mem_addr,
  output logic                    o_mem_wen,
  output logic [3:0]              o_mem_wstrb,
  output logic [31:0]             o_mem_wdata,
  input  logic                    i_mem_rvalid,
  input  logic [31:0]             i_mem_rdata,
  output logic                    o_rd_wen,
  output logic [REGIDX_WIDTH-1:0] o_rd_addr,
  output logic [31:0]             o_rd_data,
  output logic                    o_store_done,
  output logic                    o_fault
);
  lsu_state_e state, nxt;

  logic                    is_store_q;
  logic [2:0]              f3_q;
  logic [31:0]             addr_q, sdata_q, rdata_q;
  logic [REGIDX_WIDTH-1:0] rd_q;

  logic        idle, accept, bad, in_req, sel_store;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr, sel_sdata, wdata, load_data;
  logic [3:0]  wstrb;

  assign idle   = (state == IDLE);
  assign in_req = (state == REQ);
  assign accept = i_req_valid && idle;

  // The aligner sees the live request while idle (for the legality check at
  // accept) and the captured request for the rest of the operation.
  assign sel_store = idle ? i_is_store   : is_store_q;
  assign sel_f3    = idle ? i_funct3     : f3_q;
  assign sel_addr  = idle ? i_addr       : addr_q;
  assign sel_sdata = idle ? i_store_data : sdata_q;

  lsu_align u_align (
    .is_store  (sel_store),
    .funct3    (sel_f3),
    .addr_lo   (sel_addr[1:0]),
    .store_data(sel_sdata),
    .rdata     (i_mem_rdata),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .load_data (load_data),
    .bad       (bad)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0;
      sdata_q    <= 32'h0;
      rd_q       <= '0;
      rdata_q    <= 32'h0;
    end else begin
      state <= nxt;
      if (accept) begin
        is_store_q <= i_is_store;
        f3_q       <= i_funct3;
        addr_q     <= i_addr;
        sdata_q    <= i_store_data;
        rd_q       <= i_rd_addr;
      end
      if ((state == WAIT) && i_mem_rvalid) rdata_q <= load_data;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = bad ? FAULT : REQ;
      REQ:     if (i_mem_ready) nxt = is_store_q ? DONE : WAIT;
      WAIT:    if (i_mem_rvalid) nxt = WB;
      WB:      nxt = IDLE;
      DONE:    nxt = IDLE;
      FAULT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Every output decodes from registered state, so async reset clears them at once.
  assign o_req_ready  = idle;
  assign o_mem_valid  = in_req;
  assign o_mem_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign o_mem_wen    = in_req && is_store_q;
  assign o_mem_wstrb  = in_req ? wstrb : 4'b0000;
  assign o_mem_wdata  = (in_req && is_store_q) ? wdata : 32'h0;
  assign o_rd_wen     = (state == WB) && (rd_q != '0);
  assign o_rd_addr    = (state == WB) ? rd_q : '0;
  assign o_rd_data    = (state == WB) ? rdata_q : 32'h0;
  assign o_store_done = (state == DONE);
  assign o_fault      = (state == FAULT);
endmodule

// File: tb/tb_lsu_wb.sv
// Scoreboard bench for lsu_wb: directed operations push expected memory requests,
// writebacks, store completions and faults (with cycle numbers); a monitor pops and compares.
module tb_lsu_wb;
  import singlecycle_pkg::*;

  localparam int K_MEM = 0, K_WB = 1, K_DONE = 2, K_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic [4:0]  rd_addr = 5'd0;
  logic        mem_valid, mem_ready = 1'b0, mem_wen, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
  logic [3:0]  mem_wstrb;
  logic        rd_wen, store_done, fault;
  logic [4:0]  rd_out;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  lsu_wb dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr),
    .i_store_data(store_data), .i_rd_addr(rd_addr),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_wen(mem_wen), .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_rd_wen(rd_wen), .o_rd_addr(rd_out), .o_rd_data(rd_data),
    .o_store_done(store_done), .o_fault(fault)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        w;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w);
    exp_t e;
    e.kind = k; e.cyc = c; e.a = a; e.d = d; e.s = s; e.w = w;
    q.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input string n, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic w);
    exp_t e;
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: unexpected event at cycle %0d, nothing expected", n, cyc);
      return;
    end
    e = q.pop_front();
    chk({n, " kind"}, kind, e.kind);
    chk({n, " cycle"}, cyc, e.cyc);
    if (kind == K_MEM) begin
      chk({n, " addr"}, a, e.a);
      chk({n, " wen"}, {31'b0, w}, {31'b0, e.w});
      chk({n, " wstrb"}, {28'b0, s}, {28'b0, e.s});
      if (e.w) chk({n, " wdata"}, d, e.d);
    end else if (kind == K_WB) begin
      chk({n, " rd"}, a, e.a);
      chk({n, " data"}, d, e.d);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_valid && mem_ready) pop_chk(K_MEM, "memreq", mem_addr, mem_wdata, mem_wstrb, mem_wen);
      if (rd_wen)     pop_chk(K_WB, "writeback", {27'b0, rd_out}, rd_data, 4'b0, 1'b0);
      if (store_done) pop_chk(K_DONE, "store_done", 32'h0, 32'h0, 4'b0, 1'b0);
      if (fault)      pop_chk(K_FAULT, "fault", 32'h0, 32'h0, 4'b0, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 30) begin step(); n++; end
    if (!req_ready) chk("idle timeout", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, output int c0);
    wait_idle();
    c0 = cyc;
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd_addr = rd;
    step();
    // scramble fields to prove they were captured at accept
    req_valid = 1'b0; is_store = ~st; funct3 = ~f3; addr = ~a; store_data = ~sd; rd_addr = ~rd;
  endtask

  task automatic handshake(input int rdly, input logic [31:0] ea, input logic ew);
    for (int k = 0; k <= rdly; k++) begin
      mem_ready = (k == rdly);
      if (k < rdly) begin
        #2;
        chk("hold valid", {31'b0, mem_valid}, 32'h1);
        chk("hold addr", mem_addr, ea);
        chk("hold wen", {31'b0, mem_wen}, {31'b0, ew});
      end
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                          input int rdly, input logic [31:0] ea, input logic [3:0] es,
                          input logic [31:0] ewd);
    int c0;
    issue(1'b1, f3, a, sd, 5'd0, c0);
    push(K_MEM, c0 + 1 + rdly, ea, ewd, es, 1'b1);
    push(K_DONE, c0 + 2 + rdly, 0, 0, 0, 0);
    handshake(rdly, ea, 1'b1);
    step();
    chk("store ready back", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] rdata, input int rdly, input int rv,
                         input logic [31:0] ea, input logic [31:0] ed);
    int c0;
    issue(1'b0, f3, a, 32'h5555_AAAA, rd, c0);
    push(K_MEM, c0 + 1 + rdly, ea, 0, 4'b0000, 1'b0);
    if (rd != 0) push(K_WB, c0 + 2 + rdly + rv, {27'b0, rd}, ed, 0, 0);
    handshake(rdly, ea, 1'b0);
    repeat (rv - 1) step();
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0; mem_rdata = ~rdata;
    step();
    chk("load ready back", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic do_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int c0;
    issue(st, f3, a, 32'h1111_2222, 5'd4, c0);
    push(K_FAULT, c0 + 1, 0, 0, 0, 0);
    step();
    chk("fault ready back", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic chk_quiet(input string n);
    chk({n, " req_ready"}, {31'b0, req_ready}, 32'h1);
    chk({n, " mem_valid"}, {31'b0, mem_valid}, 32'h0);
    chk({n, " mem_addr"}, mem_addr, 32'h0);
    chk({n, " mem_wstrb"}, {28'b0, mem_wstrb}, 32'h0);
    chk({n, " rd_wen"}, {31'b0, rd_wen}, 32'h0);
    chk({n, " rd_data"}, rd_data, 32'h0);
    chk({n, " store_done"}, {31'b0, store_done}, 32'h0);
    chk({n, " fault"}, {31'b0, fault}, 32'h0);
  endtask

  initial begin
    int c0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk_quiet("reset");
    step();
    rst_n = 1'b1;
    step();

    do_store(F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    do_store(F3_B, 32'h0000_0103, 32'h1234_56A5, 0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    do_store(F3_H, 32'h0000_0102, 32'h7777_BEEF, 1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);
    do_load(F3_B,  32'h0000_0102, 5'd7, 32'h1280_3456, 0, 1, 32'h0000_0100, 32'hFFFF_FF80);
    do_load(F3_BU, 32'h0000_0102, 5'd7, 32'h1280_3456, 0, 1, 32'h0000_0100, 32'h0000_0080);
    do_load(F3_W,  32'h0000_0200, 5'd3, 32'hCAFE_F00D, 3, 2, 32'h0000_0200, 32'hCAFE_F00D);
    do_load(F3_HU, 32'h0000_0102, 5'd9, 32'h8765_1234, 0, 1, 32'h0000_0100, 32'h0000_8765);
    do_load(F3_H,  32'h0000_0106, 5'd10, 32'h8765_1234, 0, 1, 32'h0000_0104, 32'hFFFF_8765);
`ifdef LSU_MISALIGN_CHECK_EN
    do_fault(1'b0, F3_H, 32'h0000_0101);
    do_fault(1'b1, F3_W, 32'h0000_0102);
`else
    do_load(F3_H, 32'h0000_0101, 5'd9, 32'h1234_8765, 0, 1, 32'h0000_0100, 32'hFFFF_8765);
    do_store(F3_W, 32'h0000_0102, 32'h0BAD_F00D, 0, 32'h0000_0100, 4'b1111, 32'h0BAD_F00D);
`endif
    // load to x0 still reaches memory but never writes back
    do_load(F3_W, 32'h0000_0040, 5'd0, 32'h1234_5678, 0, 1, 32'h0000_0040, 32'h0);
    do_fault(1'b0, 3'b011, 32'h0000_0100);
    do_fault(1'b0, 3'b110, 32'h0000_0100);
    do_fault(1'b1, 3'b011, 32'h0000_0100);
    do_fault(1'b1, 3'b100, 32'h0000_0100);

    // reset while waiting for read data; the late response must be dropped
    issue(1'b0, F3_W, 32'h0000_0300, 32'h0, 5'd5, c0);
    push(K_MEM, c0 + 1, 32'h0000_0300, 0, 4'b0000, 1'b0);
    handshake(0, 32'h0000_0300, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_quiet("mid reset");
    step();
    rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
    step();
    mem_rvalid = 1'b0;
    repeat (3) step();
    chk("post reset ready", {31'b0, req_ready}, 32'h1);

    do_load(F3_B, 32'h0000_0101, 5'd1, 32'h0000_7F00, 0, 1, 32'h0000_0100, 32'h0000_007F);

    repeat (3) step();
    chk("queue drained", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
